spi_slave_shifter: RTL

//  SPI slave bit engine consuming the single-cycle SCLK edge pulses made by the upstream

---
 rtl/spi_slave_shifter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_shifter.sv
// SPI slave bit engine: shifts MOSI into receive words and drives MISO from transmit
// words, paced by single-cycle SCLK edge pulses on the system clock.
module spi_slave_shifter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sclk_lead,
  input  logic                  sclk_trail,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err
);

  localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_miso;
  logic                  r_miso_oe;
  logic                  r_rx_valid;
  logic                  r_frame_err;

  logic                  w_load;
  logic                  w_sample;
  logic                  w_drive;
  logic                  w_abort;
  logic [DATA_WIDTH-1:0] w_rx_word;
  logic [DATA_WIDTH-1:0] w_tx_word;
  logic                  w_tx_first;
  logic [DATA_WIDTH-1:0] w_tx_load_rest;
  logic                  w_tx_next;
  logic [DATA_WIDTH-1:0] w_tx_shifted;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle actions; cs_n deselect outranks any edge pulse
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sample    = 1'b0;
    w_drive     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!cs_n) begin
          w_state_nxt = ST_SHIFT;
          // Word-load pulses are combinational, so hold them off while reset is active
          w_load      = (CPHA == 1'b0) && rst_n;
        end
      end
      ST_SHIFT: begin
        if (cs_n) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else if (sclk_lead ^ sclk_trail) begin
          w_sample = CPHA ? sclk_trail : sclk_lead;
          if (CPHA ? sclk_lead : sclk_trail) begin
            if (r_bit_cnt == '0) begin
              w_load = 1'b1;
            end else begin
              w_drive = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_rx_word      = MSB_FIRST ? {r_rx_shift[DATA_WIDTH-2:0], mosi}
                                    : {mosi, r_rx_shift[DATA_WIDTH-1:1]};
  assign w_tx_word      = tx_valid ? tx_data : '0;
  assign w_tx_first     = MSB_FIRST ? w_tx_word[DATA_WIDTH-1] : w_tx_word[0];
  assign w_tx_load_rest = MSB_FIRST ? {w_tx_word[DATA_WIDTH-2:0], 1'b0}
                                    : {1'b0, w_tx_word[DATA_WIDTH-1:1]};
  assign w_tx_next      = MSB_FIRST ? r_tx_shift[DATA_WIDTH-1] : r_tx_shift[0];
  assign w_tx_shifted   = MSB_FIRST ? {r_tx_shift[DATA_WIDTH-2:0], 1'b0}
                                    : {1'b0, r_tx_shift[DATA_WIDTH-1:1]};

  // Bit datapath: miso holds the bit on the wire, r_tx_shift the bits still to send
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_rx_data   <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_miso_oe   <= (w_state_nxt == ST_SHIFT);
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_abort) begin
        r_frame_err <= (r_bit_cnt != '0);
        r_bit_cnt   <= '0;
        r_rx_shift  <= '0;
        r_tx_shift  <= '0;
        r_miso      <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_shift <= w_rx_word;
          if (r_bit_cnt == CNT_LAST) begin
            r_bit_cnt  <= '0;
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        if (w_load) begin
          r_miso     <= w_tx_first;
          r_tx_shift <= w_tx_load_rest;
        end else if (w_drive) begin
          r_miso     <= w_tx_next;
          r_tx_shift <= w_tx_shifted;
        end
      end
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = r_miso_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign tx_ready    = w_load & tx_valid;
  assign tx_underrun = w_load & ~tx_valid;

endmodule
